// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg: shared MDU op encoding and default latencies for e_mdu, the
// instruction decoder and the hazard unit.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;
  localparam logic [2:0] MDU_MADD  = 3'b111;

  localparam int MDU_MULT_LAT_DEF = 5;
  localparam int MDU_DIV_LAT_DEF  = 10;

endpackage

`default_nettype wire

// File: rtl/e_mdu_calc.sv
// ============================================================================
// e_mdu_calc: combinational product / quotient / remainder datapath.
// Optional feature macro: MDU_MADD_EN (op 111 uses a signed product).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  logic                 w_mul_signed;
  logic                 w_div_signed;
  logic                 w_is_div;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH-1:0]     w_divisor;
  logic [WIDTH-1:0]     w_uq;
  logic [WIDTH-1:0]     w_ur;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;

  always_comb begin
    w_mul_signed = (op == MDU_MULT);
`ifdef MDU_MADD_EN
    w_mul_signed = w_mul_signed | (op == MDU_MADD);
`endif
    w_div_signed = (op == MDU_DIV);
    w_is_div     = (op == MDU_DIV) || (op == MDU_DIVU);

    w_a_ext = w_mul_signed ? {{WIDTH{dataA[WIDTH-1]}}, dataA} : {{WIDTH{1'b0}}, dataA};
    w_b_ext = w_mul_signed ? {{WIDTH{dataB[WIDTH-1]}}, dataB} : {{WIDTH{1'b0}}, dataB};
    w_prod  = w_a_ext * w_b_ext;

    // Signed divide runs on magnitudes through one unsigned divider; the
    // most-negative / -1 case then falls out as quotient 0x80..0, remainder 0.
    w_neg_a   = w_div_signed & dataA[WIDTH-1];
    w_neg_b   = w_div_signed & dataB[WIDTH-1];
    w_mag_a   = w_neg_a ? (~dataA + 1'b1) : dataA;
    w_mag_b   = w_neg_b ? (~dataB + 1'b1) : dataB;
    div_zero  = (dataB == '0);
    w_divisor = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
    w_uq      = w_mag_a / w_divisor;
    w_ur      = w_mag_a % w_divisor;
    w_quot    = (w_neg_a ^ w_neg_b) ? (~w_uq + 1'b1) : w_uq;
    w_rem     = w_neg_a ? (~w_ur + 1'b1) : w_ur;

    if (w_is_div) begin
      res_hi = w_rem;
      res_lo = w_quot;
    end else begin
      res_hi = w_prod[2*WIDTH-1:WIDTH];
      res_lo = w_prod[WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
// e_mdu: fixed-latency multiply/divide unit owning HI/LO, with busy flag.
// Optional feature macro: MDU_MADD_EN (op 111 = signed multiply-accumulate).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_div_zero;
  logic             w_accept;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             wb_q, wb_d;
  logic [WIDTH-1:0] shadow_hi_q, shadow_hi_d;
  logic [WIDTH-1:0] shadow_lo_q, shadow_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MDU_MADD_EN
  logic             madd_q, madd_d;
`endif

  e_mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op       (op),
    .dataA    (dataA),
    .dataB    (dataB),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_div_zero)
  );

  assign w_accept = start && !busy_q;

  always_comb begin
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    wb_d        = wb_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
`ifdef MDU_MADD_EN
    madd_d      = madd_q;
`endif

    if (w_accept) begin
      case (op)
        MDU_MTHI: hi_d = dataA;
        MDU_MTLO: lo_d = dataA;
        MDU_MULT, MDU_MULTU: begin
          shadow_hi_d = w_res_hi;
          shadow_lo_d = w_res_lo;
          cnt_d       = CNT_W'(MULT_LAT);
          busy_d      = 1'b1;
          wb_d        = 1'b1;
`ifdef MDU_MADD_EN
          madd_d      = 1'b0;
`endif
        end
        MDU_DIV, MDU_DIVU: begin
          shadow_hi_d = w_res_hi;
          shadow_lo_d = w_res_lo;
          cnt_d       = CNT_W'(DIV_LAT);
          busy_d      = 1'b1;
          // A zero divisor still occupies the unit but leaves HI/LO alone.
          wb_d        = !w_div_zero;
`ifdef MDU_MADD_EN
          madd_d      = 1'b0;
`endif
        end
`ifdef MDU_MADD_EN
        MDU_MADD: begin
          shadow_hi_d = w_res_hi;
          shadow_lo_d = w_res_lo;
          cnt_d       = CNT_W'(MULT_LAT);
          busy_d      = 1'b1;
          wb_d        = 1'b1;
          madd_d      = 1'b1;
        end
`endif
        default: ;
      endcase
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (wb_q) begin
`ifdef MDU_MADD_EN
          // Accumulate against HI/LO as they stand at completion.
          if (madd_q) begin
            {hi_d, lo_d} = {hi_q, lo_q} + {shadow_hi_q, shadow_lo_q};
          end else begin
            hi_d = shadow_hi_q;
            lo_d = shadow_lo_q;
          end
`else
          hi_d = shadow_hi_q;
          lo_d = shadow_lo_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      wb_q        <= 1'b0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
`ifdef MDU_MADD_EN
      madd_q      <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      wb_q        <= wb_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
`ifdef MDU_MADD_EN
      madd_q      <= madd_d;
`endif
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Parametrised multiply/divide unit for the execute stage of the pipelined MIPS core. Sits beside the combinational ALU and owns the HI/LO registers. Runs signed and unsigned mult/div as fixed-latency multi-cycle operations, and accepts mthi/mtlo writes. Exposes a busy flag that the hazard unit uses to stall mfhi/mflo and any further MDU instructions.

Parameters:
WIDTH, 32, operand and HI/LO width in bits
MULT_LAT, 5, cycles busy stays high for mult/multu (must be >= 1)
DIV_LAT, 10, cycles busy stays high for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle pulse; an MDU instruction is in E this cycle
op  input  3  operation code, sampled when start=1
dataA  input  WIDTH  rs operand
dataB  input  WIDTH  rt operand
busy  output  1  registered; high while mult/div is in progress
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-high. Reset forces busy=0, hi=0, lo=0, counter=0, shadow results=0.
- op encoding: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none unless MDU_MADD_EN is defined).
- Accept condition: start=1 and busy=0. If start=1 while busy=1, the request is ignored and state is unchanged; the hazard unit prevents this case.
- mthi/mtlo: on the accepting edge, hi (or lo) <= dataA. Busy stays 0; the new value is visible the next cycle.
- mult/multu, when accepted at edge T:
  - The full 2*WIDTH product of dataA and dataB is computed (signed for mult, zero-extended for multu) and latched into shadow registers.
  - counter <= MULT_LAT and busy <= 1.
- div/divu: same sequence with DIV_LAT.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Results: lo = quotient, hi = remainder.
  - Signed overflow (most-negative / -1): lo = 0x80..0, hi = 0.
  - Divide by zero: the op is still accepted and busy still asserts for DIV_LAT cycles, but hi/lo are left unchanged on completion.
- Counting: while busy, counter decrements by one each edge. On the edge where counter moves from 1 to 0:
  - busy <= 0;
  - hi <= shadow hi and lo <= shadow lo (mult: hi = product upper half, lo = lower half).
- Latency: busy is high for exactly MULT_LAT (or DIV_LAT) cycles starting at cycle T+1. New hi/lo are visible in the first cycle after busy falls.
- Reset asserted mid-operation aborts the operation. hi/lo return to 0 and no late write-back occurs.
- hi/lo hold their values whenever no write or completion event occurs.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: op 111 = madd. The signed product is added to the 2*WIDTH value {hi,lo}, with MULT_LAT latency and the same busy and write-back rules. Wrap-around modulo 2^(2*WIDTH). The accumulate uses the {hi,lo} value at completion time.
- Not defined: op 111 behaves as none. No accumulate adder is synthesised.

Decomposition:
- Package mdu_pkg: op encoding localparams (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD) and default latency constants. The decoder and the hazard unit share this package.
- One sub-module is natural: e_mdu_calc. It is purely combinational, computes the product/quotient/remainder and the divide-by-zero flag from op, dataA and dataB, and is parametrised by WIDTH.
- e_mdu keeps the counter, busy flag, shadow registers and HI/LO.

Test Plan:
1. reset pulse mid-idle -> hi=0, lo=0, busy=0 immediately, without waiting for a clock edge.
2. mult dataA=0xFFFFFFFF (-1), dataB=2 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
3. div dataA=-7 (0xFFFFFFF9), dataB=2 -> busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 with hi/lo preset to 0x11/0x22 -> busy for 10 cycles, hi/lo unchanged.
4. mthi 0xDEADBEEF, then mtlo 0x12345678 on consecutive cycles -> busy never asserts, hi/lo hold those values.
5. mult issued, a second start (div) issued while busy, reset asserted at busy cycle 3 -> second op ignored, busy=0 and hi=lo=0 at once, no write-back afterwards.
6. With MDU_MADD_EN: {hi,lo}=0x00000000_FFFFFFFF, madd 1*1 -> after 5 cycles hi=0x00000001, lo=0x00000000. Without the macro, op 111 -> no busy, no change.
